// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - two-stage valid/ready immediate sign/zero extender with optional negation.
// Optional IMM_EXT_NEG_SAT_EN: saturate negation overflow and flag out-of-range zext results.
module imm_ext_pipe #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MAX_POS = ~MIN_NEG;

  logic             s1_valid;
  logic             s1_neg;
  logic [OUT_W-1:0] s1_ext;
  logic             s1_ld;
  logic             s2_ld;
  logic [OUT_W-1:0] ext_d;
  logic [OUT_W-1:0] neg_val;
  logic [OUT_W-1:0] res_d;

  assign s2_ld    = !out_valid | out_ready;
  assign s1_ld    = !s1_valid | s2_ld;
  assign in_ready = s1_ld;

  always_comb begin
    ext_d = in_mode[0] ? OUT_W'(in_imm) : OUT_W'($signed(in_imm));
  end

  assign neg_val = ~s1_ext + OUT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_ext   <= '0;
    end else if (s1_ld) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ext <= ext_d;
        s1_neg <= in_mode[1];
      end
    end
  end

`ifdef IMM_EXT_NEG_SAT_EN
  logic s1_zext;
  logic ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_zext <= 1'b0;
    end else if (s1_ld && in_valid) begin
      s1_zext <= in_mode[0];
    end
  end

  // Only ext == 100..0 can overflow on negation; a full-width zext with MSB set is out of signed range.
  always_comb begin
    res_d = s1_neg ? neg_val : s1_ext;
    ovf_d = 1'b0;
    if (s1_neg && (s1_ext == MIN_NEG)) begin
      res_d = MAX_POS;
      ovf_d = 1'b1;
    end
    if ((IN_W == OUT_W) && s1_zext && s1_ext[OUT_W-1]) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ovf <= 1'b0;
    end else if (s2_ld && s1_valid) begin
      out_ovf <= ovf_d;
    end
  end
`else
  always_comb begin
    res_d = s1_neg ? neg_val : s1_ext;
  end

  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_ld) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (out_valid && out_ready) begin
      out_cnt <= out_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - randomized and directed bench for imm_ext_pipe with a queue-based reference model.
module tb_imm_ext_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic [15:0] out_cnt;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_imm;
  logic [1:0]  b_mode;
  logic        b_out_valid;
  logic        b_ready;
  logic [7:0]  b_data;
  logic        b_ovf;
  logic [3:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] out_log[$];
  int          exp_cnt;
  logic        held;
  logic [31:0] held_data;
  logic [31:0] last_out;
  logic        acc;

  imm_ext_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_cnt(out_cnt)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_imm(b_imm), .in_mode(b_mode), .out_valid(b_out_valid), .out_ready(b_ready),
    .out_data(b_data), .out_ovf(b_ovf), .out_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret the immediate as an integer, negate arithmetically, reduce mod 2^32.
  function automatic logic [31:0] ref_out(input logic [11:0] imm, input logic [1:0] mode);
    longint v;
    if (mode[0] || !imm[11]) v = longint'(imm);
    else                     v = longint'(imm) - 4096;
    if (mode[1]) v = -v;
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (held) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'(held_data));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(exp_q.size()), 64'd1);
      end else begin
        chk("data", 64'(out_data), 64'(exp_q[0]));
        chk("ovf", 64'(out_ovf), 64'd0);
        void'(exp_q.pop_front());
        last_out = out_data;
        out_log.push_back(out_data);
        exp_cnt++;
      end
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(ref_out(in_imm, in_mode));
    held      = out_valid && !out_ready;
    held_data = out_data;
    @(posedge clk);
    #1;
    chk("cnt", 64'(out_cnt), 64'(exp_cnt[15:0]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    held    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [11:0] imm, input logic [1:0] mode, input logic [31:0] exp);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("directed", 64'(last_out), 64'(exp));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_idle", 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_imm = '0; b_mode = '0; b_ready = 1'b1;
    exp_cnt = 0; held = 1'b0; last_out = '0; acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_out_cnt", 64'(out_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    step();

    send(12'h005, 2'b00, 32'h0000_0005);
    send(12'hFFB, 2'b00, 32'hFFFF_FFFB);
    send(12'hFFB, 2'b01, 32'h0000_0FFB);
    send(12'hFFB, 2'b10, 32'h0000_0005);
    send(12'hFFB, 2'b11, 32'hFFFF_F005);
    send(12'h000, 2'b10, 32'h0000_0000);
    send(12'hFFF, 2'b11, 32'hFFFF_F001);

    // Backpressure mid-stream: two accepts fill both stages, then in_ready must drop.
    out_log.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_imm    = 12'd1337;
    step();
    in_imm = 12'h81D;
    step();
    in_imm = 12'd12;
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    step();
    step();
    chk("stall_data", 64'(out_data), 64'h539);
    out_ready = 1'b1;
    step();
    chk("resume_accept", 64'(acc), 64'd1);
    drain();
    chk("stream_len", 64'(out_log.size()), 64'd3);
    if (out_log.size() == 3) begin
      chk("stream_0", 64'(out_log[0]), 64'h0000_0539);
      chk("stream_1", 64'(out_log[1]), 64'hFFFF_F81D);
      chk("stream_2", 64'(out_log[2]), 64'h0000_000C);
    end

    // Every 12-bit value through sext+neg with random output stalls.
    do_reset();
    for (int i = 0; i < 4096; i++) begin
      int k;
      in_valid = 1'b1;
      in_imm   = 12'(i);
      in_mode  = 2'b10;
      k = 0;
      do begin
        out_ready = ($urandom_range(0, 3) != 0);
        step();
        k++;
      end while (!acc && k < 50);
      if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    end
    drain();
    chk("cnt_4096", 64'(out_cnt), 64'd4096);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_imm    = 12'($urandom);
      in_mode   = 2'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    // Reset while both stages are full discards everything at once.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b01;
    in_imm    = 12'($urandom);
    step();
    step();
    chk("full_before_rst", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_cnt", 64'(out_cnt), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    exp_cnt  = 0;
    held     = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();
    chk("no_partial_out", 64'(out_valid), 64'd0);

    // Full-width instance: negation overflow and a 4-bit wrapping counter.
    b_in_valid = 1'b1;
    b_mode     = 2'b10;
    b_imm      = 8'h80;
    step();
    b_imm = 8'($urandom);
    step();
    chk("b_valid", 64'(b_out_valid), 64'd1);
`ifdef IMM_EXT_NEG_SAT_EN
    chk("b_neg_sat_data", 64'(b_data), 64'h7F);
    chk("b_neg_sat_ovf", 64'(b_ovf), 64'd1);
`else
    chk("b_neg_data", 64'(b_data), 64'h80);
    chk("b_neg_ovf", 64'(b_ovf), 64'd0);
`endif
    for (int i = 0; i < 15; i++) begin
      b_imm = 8'($urandom);
      step();
    end
    b_in_valid = 1'b0;
    repeat (3) step();
    chk("b_cnt_wrap", 64'(b_cnt), 64'd1);
    chk("b_ready_idle", 64'(b_in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
